// File: rtl/ex_stage.sv
// Execute stage: an ID/EX pipeline register, a one-hot ALU, and a multi-cycle restoring divider.
// It also drives the data memory, the ID forwarding bus, and the write-back control passed to MEM.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_inst,
    input  logic [11:0] alu_op,
    input  logic [2:0]  sel_src1,
    input  logic [3:0]  sel_src2,
    input  logic        data_ram_en,
    input  logic [3:0]  data_ram_wen,
    input  logic        rf_we,
    input  logic [4:0]  rf_waddr,
    input  logic        sel_rf_res,
    input  logic [1:0]  div_op,
    input  logic [31:0] rdata1,
    input  logic [31:0] rdata2,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    output logic        ex_rf_we,
    output logic [4:0]  ex_rf_waddr,
    output logic [31:0] ex_rf_wdata,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_result,
    output logic        ex_rf_we_o,
    output logic [4:0]  ex_rf_waddr_o,
    output logic        ex_sel_rf_res,
    output logic        ex_is_load,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stallreq_ex
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  sel_src1;
        logic [3:0]  sel_src2;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sel_rf_res;
        logic [1:0]  div_op;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
    } id_ex_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    id_ex_t     id_in;
    id_ex_t     id_ex_d, id_ex_q;
    div_state_t state_d, state_q;
    logic [4:0]  cnt_d, cnt_q;
    logic [31:0] quot_d, quot_q;
    logic [31:0] rem_d, rem_q;
    logic [31:0] dvs_d, dvs_q;
    logic        neg_quot_d, neg_quot_q;
    logic        neg_rem_d, neg_rem_q;
    logic        div_done_d, div_done_q;
    logic [31:0] hi_d, hi_q;
    logic [31:0] lo_d, lo_q;

    logic        pipe_load;
    logic        pipe_bubble;
    logic [31:0] src1, src2, alu_res;
    logic [31:0] imm_sext, imm_zext;
    logic [4:0]  shamt;

    logic        div_signed;
    logic        div_pending;
    logic [31:0] abs_a, abs_b;
    logic [32:0] rem_shift;
    logic [32:0] rem_diff;
    logic        take;
    logic [31:0] rem_step, quot_step;
    logic [31:0] quot_fin, rem_fin;

    logic        unused_bits;

    assign pipe_load   = ~stall[2];
    assign pipe_bubble = stall[2] & ~stall[3];

    always_comb begin
        id_in            = '0;
        id_in.pc         = id_pc;
        id_in.inst       = id_inst;
        id_in.alu_op     = alu_op;
        id_in.sel_src1   = sel_src1;
        id_in.sel_src2   = sel_src2;
        id_in.ram_en     = data_ram_en;
        id_in.ram_wen    = data_ram_wen;
        id_in.rf_we      = rf_we;
        id_in.rf_waddr   = rf_waddr;
        id_in.sel_rf_res = sel_rf_res;
        id_in.div_op     = div_op;
        id_in.rdata1     = rdata1;
        id_in.rdata2     = rdata2;
    end

    // A stalled ID with a running EX injects a bubble; stalling both holds the register.
    always_comb begin
        id_ex_d = id_ex_q;
        if (pipe_load) begin
            id_ex_d = id_in;
        end else if (pipe_bubble) begin
            id_ex_d = '0;
        end
    end

    assign imm_sext = {{16{id_ex_q.inst[15]}}, id_ex_q.inst[15:0]};
    assign imm_zext = {16'h0000, id_ex_q.inst[15:0]};

    always_comb begin
        src1 = ({32{id_ex_q.sel_src1[0]}} & id_ex_q.rdata1)
             | ({32{id_ex_q.sel_src1[1]}} & id_ex_q.pc)
             | ({32{id_ex_q.sel_src1[2]}} & {27'd0, id_ex_q.inst[10:6]});
        src2 = ({32{id_ex_q.sel_src2[0]}} & id_ex_q.rdata2)
             | ({32{id_ex_q.sel_src2[1]}} & imm_sext)
             | ({32{id_ex_q.sel_src2[2]}} & 32'd8)
             | ({32{id_ex_q.sel_src2[3]}} & imm_zext);
    end

    assign shamt = src1[4:0];

    always_comb begin
        alu_res = '0;
        if (id_ex_q.alu_op[11]) alu_res = alu_res | (src1 + src2);
        if (id_ex_q.alu_op[10]) alu_res = alu_res | (src1 - src2);
        if (id_ex_q.alu_op[9])  alu_res = alu_res | {31'd0, $signed(src1) < $signed(src2)};
        if (id_ex_q.alu_op[8])  alu_res = alu_res | {31'd0, src1 < src2};
        if (id_ex_q.alu_op[7])  alu_res = alu_res | (src1 & src2);
        if (id_ex_q.alu_op[6])  alu_res = alu_res | ~(src1 | src2);
        if (id_ex_q.alu_op[5])  alu_res = alu_res | (src1 | src2);
        if (id_ex_q.alu_op[4])  alu_res = alu_res | (src1 ^ src2);
        if (id_ex_q.alu_op[3])  alu_res = alu_res | (src2 << shamt);
        if (id_ex_q.alu_op[2])  alu_res = alu_res | (src2 >> shamt);
        if (id_ex_q.alu_op[1])  alu_res = alu_res | 32'($signed(src2) >>> shamt);
        if (id_ex_q.alu_op[0])  alu_res = alu_res | {src2[15:0], 16'h0000};
    end

    assign div_signed  = id_ex_q.div_op[1];
    assign div_pending = (id_ex_q.div_op != 2'b00) && !div_done_q;
    assign abs_a = (div_signed && id_ex_q.rdata1[31]) ? (~id_ex_q.rdata1 + 32'd1) : id_ex_q.rdata1;
    assign abs_b = (div_signed && id_ex_q.rdata2[31]) ? (~id_ex_q.rdata2 + 32'd1) : id_ex_q.rdata2;

    // One restoring step; the partial remainder stays below the divisor, so 32 bits hold it.
    always_comb begin
        rem_shift = {rem_q, quot_q[31]};
        rem_diff  = rem_shift - {1'b0, dvs_q};
        take      = (rem_shift >= {1'b0, dvs_q});
        rem_step  = take ? rem_diff[31:0] : rem_shift[31:0];
        quot_step = {quot_q[30:0], take};
        quot_fin  = neg_quot_q ? (~quot_step + 32'd1) : quot_step;
        rem_fin   = neg_rem_q ? (~rem_step + 32'd1) : rem_step;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        neg_quot_d  = neg_quot_q;
        neg_rem_d   = neg_rem_q;
        div_done_d  = div_done_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        stallreq_ex = 1'b0;
        case (state_q)
            IDLE: begin
                if (div_pending) begin
                    stallreq_ex = 1'b1;
                    quot_d      = abs_a;
                    dvs_d       = abs_b;
                    rem_d       = '0;
                    cnt_d       = '0;
                    neg_quot_d  = div_signed && (id_ex_q.rdata1[31] ^ id_ex_q.rdata2[31]);
                    neg_rem_d   = div_signed && id_ex_q.rdata1[31];
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                stallreq_ex = 1'b1;
                quot_d      = quot_step;
                rem_d       = rem_step;
                cnt_d       = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    lo_d       = quot_fin;
                    hi_d       = rem_fin;
                    div_done_d = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A newly loaded instruction must be allowed to start its own divide.
        if (pipe_load || pipe_bubble) begin
            div_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_ex_q    <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_done_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            id_ex_q    <= id_ex_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dvs_q      <= dvs_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            div_done_q <= div_done_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign data_sram_en    = id_ex_q.ram_en & ~stallreq_ex;
    assign data_sram_wen   = (|id_ex_q.ram_wen) ? 4'b1111 : 4'b0000;
    assign data_sram_addr  = alu_res;
    assign data_sram_wdata = id_ex_q.rdata2;

    assign ex_rf_we      = id_ex_q.rf_we;
    assign ex_rf_waddr   = id_ex_q.rf_waddr;
    assign ex_rf_wdata   = alu_res;
    assign ex_pc         = id_ex_q.pc;
    assign ex_result     = alu_res;
    assign ex_rf_we_o    = id_ex_q.rf_we;
    assign ex_rf_waddr_o = id_ex_q.rf_waddr;
    assign ex_sel_rf_res = id_ex_q.sel_rf_res;
    assign ex_is_load    = id_ex_q.ram_en & id_ex_q.sel_rf_res;
    assign hi            = hi_q;
    assign lo            = lo_q;

    assign unused_bits = ^{stall[5:4], stall[1:0], id_ex_q.inst[31:16]};

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have the following ports (name, direction, width, meaning), one per line:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset; state is cleared while rst=0.
- stall  in  6  pipeline stall vector; bit 2 = ID stage, bit 3 = EX stage; 1 = stop.
- id_pc, id_inst  in  32 each  PC and instruction word of the ID-stage instruction.
- alu_op  in  12  one-hot operation, bit 11..0 = add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
- sel_src1  in  3  one-hot: [0] rs value, [1] pc, [2] zero-extended inst[10:6].
- sel_src2  in  4  one-hot: [0] rt value, [1] sign-extended imm, [2] constant 8, [3] zero-extended imm.
- data_ram_en  in  1  memory access.
- data_ram_wen  in  4  store request (any bit set = word store).
- rf_we  in  1  register write enable.
- rf_waddr  in  5  register write address.
- sel_rf_res  in  1  result comes from load.
- div_op  in  2  [1] signed divide, [0] unsigned divide.
- rdata1, rdata2  in  32 each  forwarded rs and rt values.
- data_sram_en  out  1  data memory enable.
- data_sram_wen  out  4  data memory byte write enables.
- data_sram_addr, data_sram_wdata  out  32 each  data memory address and write data.
- ex_rf_we, ex_rf_waddr, ex_rf_wdata  out  1/5/32  forwarding bus back to ID.
- ex_pc, ex_result  out  32 each  PC and result passed to MEM.
- ex_rf_we_o, ex_rf_waddr_o, ex_sel_rf_res  out  1/5/1  write-back control passed to MEM.
- ex_is_load  out  1  held instruction is a load (for load-use detection).
- hi, lo  out  32 each  divide remainder and quotient registers.
- stallreq_ex  out  1  request to hold IF, ID and EX.

Function
REQ-002 Pipeline register SHALL capture all ID inputs on a clk edge when stall[2]=0.
REQ-003 When stall[2]=1 and stall[3]=0, the pipeline register SHALL load all-zero (bubble).
REQ-004 When stall[2]=1 and stall[3]=1, the pipeline register SHALL hold its contents.
REQ-005 src1/src2 SHALL be the OR of the enabled sources; an all-zero select SHALL give 0.
REQ-006 ALU results:
- add/sub: modulo 2^32.
- slt: signed compare; sltu: unsigned compare; result is 1 or 0.
- and, nor, or, xor: bitwise.
- sll: src2 << src1[4:0]; srl: logical right shift by src1[4:0]; sra: arithmetic right shift by src1[4:0].
- lui: {src2[15:0], 16'h0}.
- all-zero alu_op: result 0.
REQ-007 ex_result and ex_rf_wdata SHALL equal the ALU result.
REQ-008 ex_rf_we SHALL equal the held rf_we; ex_rf_waddr SHALL equal the held rf_waddr.
REQ-009 Memory outputs, all combinational from the held instruction:
- data_sram_en = held data_ram_en AND NOT stallreq_ex.
- data_sram_wen = 4'b1111 if any held wen bit is set, else 4'b0000.
- data_sram_addr = ALU result.
- data_sram_wdata = held rdata2.
REQ-010 ex_is_load SHALL equal held data_ram_en AND held sel_rf_res.
REQ-011 The divider SHALL be an FSM with states IDLE, BUSY and DONE, and a 5-bit iteration counter.
REQ-012 In IDLE, when held div_op≠0 and div_done=0, the divider SHALL:
- latch |dividend| and |divisor| (plain values when unsigned);
- clear the counter;
- go to BUSY.
REQ-013 In BUSY, each cycle SHALL perform one restoring shift-subtract step; after 32 steps (counter wrap 31→0) the FSM SHALL go to DONE.
REQ-014 On entering DONE: lo ← quotient, hi ← remainder, div_done ← 1. DONE SHALL return to IDLE on the next cycle.
REQ-015 Signed divide:
- quotient is negated when operand signs differ;
- remainder takes the sign of the dividend;
- 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
REQ-016 Divide by zero: lo=0xFFFFFFFF and hi=dividend (unsigned); for signed, magnitude rules apply.
REQ-017 stallreq_ex SHALL be 1:
- in IDLE with a divide pending (held div_op≠0 and div_done=0);
- in every BUSY cycle.
It SHALL be 0 in DONE, giving 33 stall cycles per divide.
REQ-018 div_done SHALL clear whenever the pipeline register loads (REQ-002 or REQ-003), so one held divide executes exactly once.
REQ-019 hi and lo SHALL change only on the DONE transition.

Reset
REQ-020 While rst=0, the block SHALL asynchronously clear the pipeline register, FSM (to IDLE), counter, div_done, hi and lo.
REQ-021 While rst=0, all outputs SHALL be 0.
REQ-022 Reset asserted during BUSY SHALL abort the divide; hi and lo SHALL read 0 after release.

Verification
REQ-023 Bench SHALL cover:
- add: rs=7, src2 imm=0xFFFF (sign-extended) → ex_result=6 one cycle after capture.
- sra: rt=0x80000000, sa=4 → ex_result=0xF8000000.
- sltu: 1 vs 0xFFFFFFFF → 1; slt with the same operands → 0.
- unsigned divide: 100 / 7 → stallreq_ex high for 33 cycles, then lo=14, hi=2.
- signed divide: -7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; divide by 0 → lo=0xFFFFFFFF.
- load with stall[2]=1, stall[3]=0 → next cycle all outputs 0; rst pulsed low mid-BUSY → IDLE, hi=lo=0, stallreq_ex=0.
